// File: rtl/keypad_if.sv
// keypad_if: signal bundle between the keypad scanner and the keypad/consumer side.
//   col_in     : keypad columns, active-low, pulled up, asynchronous
//   row_out    : keypad rows, active-low, one row low at a time
//   num_out    : one-hot digit level (bit n = digit n committed)
//   set_pulse  : one-cycle pulse when '#' becomes the committed key
//   star_pulse : one-cycle pulse when '*' becomes the committed key
//   key_code   : committed key (0-9 digits, 10 '*', 11 '#', 15 none/multi)
//   key_valid  : exactly one key committed
//   multi_key  : committed state is two or more keys
// master = scanner side, slave = keypad matrix / downstream logic side.
interface keypad_if;
   logic [2:0] col_in;
   logic [3:0] row_out;
   logic [9:0] num_out;
   logic       set_pulse;
   logic       star_pulse;
   logic [3:0] key_code;
   logic       key_valid;
   logic       multi_key;

   modport master (
      input  col_in,
      output row_out,
      output num_out,
      output set_pulse,
      output star_pulse,
      output key_code,
      output key_valid,
      output multi_key
   );

   modport slave (
      output col_in,
      input  row_out,
      input  num_out,
      input  set_pulse,
      input  star_pulse,
      input  key_code,
      input  key_valid,
      input  multi_key
   );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 telephone keypad front end. Scans rows, samples the
// synchronized columns at the end of each row period, classifies each full
// frame (none / single key / multiple keys), debounces over whole frames and
// drives registered digit, code and pulse outputs from the committed state.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   kp  : keypad_if.master (col_in in; row_out, num_out, set_pulse,
//         star_pulse, key_code, key_valid, multi_key out)
// Parameters:
//   SCAN_DIV       : cycles each row stays driven (>= 3 so the 2-flop
//                    synchronizer latency stays inside one row period)
//   DEBOUNCE_SCANS : identical frames needed to commit a new state (1-15)
//
// Debounce state kinds (candidate and committed):
//   state     | meaning
//   KS_NONE   | no key in the frame, code held at 15
//   KS_SINGLE | exactly one key, code 0-9 digit, 10 '*', 11 '#'
//   KS_MULTI  | two or more keys, code held at 15
module keypad_scanner #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic     clk,
   input  logic     rst,
   keypad_if.master kp
);

   typedef enum logic [1:0] {
      KS_NONE   = 2'd0,
      KS_SINGLE = 2'd1,
      KS_MULTI  = 2'd2
   } key_kind_t;

   localparam int         DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0] CNT_MAX  = 4'(DEBOUNCE_SCANS);
   localparam logic [3:0] CODE_NONE = 4'hF;
   localparam logic [3:0] CODE_STAR = 4'd10;
   localparam logic [3:0] CODE_HASH = 4'd11;

   // frame bit (row*3 + col) to key code
   function automatic logic [3:0] bit_code(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:    code = 4'd1;
         4'd1:    code = 4'd2;
         4'd2:    code = 4'd3;
         4'd3:    code = 4'd4;
         4'd4:    code = 4'd5;
         4'd5:    code = 4'd6;
         4'd6:    code = 4'd7;
         4'd7:    code = 4'd8;
         4'd8:    code = 4'd9;
         4'd9:    code = CODE_STAR;
         4'd10:   code = 4'd0;
         4'd11:   code = CODE_HASH;
         default: code = CODE_NONE;
      endcase
      return code;
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       row_idx;
   logic [2:0]       col_s1;
   logic [2:0]       col_s2;
   logic [11:0]      frame;
   logic             frame_done;
   logic             row_end;

   assign row_end = (div_cnt == DIV_LAST);

   // Row scan, column synchronizer and frame capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt    <= '0;
         row_idx    <= 2'd0;
         kp.row_out <= 4'b1110;
         col_s1     <= 3'b111;
         col_s2     <= 3'b111;
         frame      <= '0;
         frame_done <= 1'b0;
      end else begin
         col_s1     <= kp.col_in;
         col_s2     <= col_s1;
         frame_done <= 1'b0;
         if (row_end) begin
            div_cnt    <= '0;
            row_idx    <= row_idx + 2'd1;
            kp.row_out <= {kp.row_out[2:0], kp.row_out[3]};
            case (row_idx)
               2'd0:    frame[2:0]  <= ~col_s2;
               2'd1:    frame[5:3]  <= ~col_s2;
               2'd2:    frame[8:6]  <= ~col_s2;
               default: frame[11:9] <= ~col_s2;
            endcase
            // frame is complete one cycle after the row-3 sample
            frame_done <= (row_idx == 2'd3);
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Frame classification.
   logic      frame_any;
   logic      frame_many;
   logic [3:0] frame_code;
   key_kind_t new_kind;
   logic [3:0] new_code;

   always_comb begin
      frame_any  = 1'b0;
      frame_many = 1'b0;
      frame_code = CODE_NONE;
      for (int i = 0; i < 12; i++) begin
         if (frame[i]) begin
            if (frame_any) frame_many = 1'b1;
            frame_any  = 1'b1;
            frame_code = bit_code(4'(i));
         end
      end
      if (frame_many) begin
         new_kind = KS_MULTI;
         new_code = CODE_NONE;
      end else if (frame_any) begin
         new_kind = KS_SINGLE;
         new_code = frame_code;
      end else begin
         new_kind = KS_NONE;
         new_code = CODE_NONE;
      end
   end

   // Debounce: candidate/stable counter and committed state.
   key_kind_t  cand_kind;
   key_kind_t  cand_kind_n;
   logic [3:0] cand_code;
   logic [3:0] cand_code_n;
   logic [3:0] stable_cnt;
   logic [3:0] stable_n;
   key_kind_t  comm_kind;
   key_kind_t  comm_kind_n;
   logic [3:0] comm_code;
   logic [3:0] comm_code_n;
   logic       commit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_kind  <= KS_NONE;
         cand_code  <= CODE_NONE;
         stable_cnt <= 4'd0;
         comm_kind  <= KS_NONE;
         comm_code  <= CODE_NONE;
      end else begin
         cand_kind  <= cand_kind_n;
         cand_code  <= cand_code_n;
         stable_cnt <= stable_n;
         comm_kind  <= comm_kind_n;
         comm_code  <= comm_code_n;
      end
   end

   always_comb begin
      cand_kind_n = cand_kind;
      cand_code_n = cand_code;
      stable_n    = stable_cnt;
      comm_kind_n = comm_kind;
      comm_code_n = comm_code;
      commit      = 1'b0;
      if (frame_done) begin
         if (new_kind == cand_kind && new_code == cand_code) begin
            if (stable_cnt < CNT_MAX) stable_n = stable_cnt + 4'd1;
         end else begin
            cand_kind_n = new_kind;
            cand_code_n = new_code;
            stable_n    = 4'd1;
         end
         // commit on the same edge the counter reaches the threshold
         if (stable_n == CNT_MAX &&
             (cand_kind_n != comm_kind || cand_code_n != comm_code)) begin
            commit      = 1'b1;
            comm_kind_n = cand_kind_n;
            comm_code_n = cand_code_n;
         end
      end
   end

   // Registered outputs, updated from the state being committed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kp.num_out    <= '0;
         kp.set_pulse  <= 1'b0;
         kp.star_pulse <= 1'b0;
         kp.key_code   <= CODE_NONE;
         kp.key_valid  <= 1'b0;
         kp.multi_key  <= 1'b0;
      end else begin
         kp.set_pulse  <= commit && comm_kind_n == KS_SINGLE && comm_code_n == CODE_HASH;
         kp.star_pulse <= commit && comm_kind_n == KS_SINGLE && comm_code_n == CODE_STAR;
         if (commit) begin
            if (comm_kind_n == KS_SINGLE && comm_code_n <= 4'd9)
               kp.num_out <= 10'd1 << comm_code_n;
            else
               kp.num_out <= '0;
            kp.key_code  <= (comm_kind_n == KS_SINGLE) ? comm_code_n : CODE_NONE;
            kp.key_valid <= (comm_kind_n == KS_SINGLE);
            kp.multi_key <= (comm_kind_n == KS_MULTI);
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with default
// parameters (16-cycle frames). A keypad matrix model ties each column to the
// rows of pressed keys. Expected output changes are queued when stimulus is
// applied and popped by a monitor whenever the outputs change.
module tb_keypad_scanner;

   localparam int K1 = 0, K2 = 1, K3 = 2, K5 = 4, K7 = 6, K8 = 7, KH = 11;
   localparam logic [15:0] NONE_T  = {10'd0, 4'hF, 1'b0, 1'b0};
   localparam logic [15:0] MULTI_T = {10'd0, 4'hF, 1'b0, 1'b1};
   localparam logic [15:0] HASH_T  = {10'd0, 4'd11, 1'b1, 1'b0};

   typedef struct {
      int          due;
      logic [15:0] tup;
      logic        set_e;
      logic        star_e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] pressed = '0;
   logic [2:0]  col_v;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          set_cnt = 0;
   int          star_cnt = 0;
   bit          mon_on = 1'b0;
   exp_t        exp_q[$];

   keypad_if kp ();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   always #5 clk = ~clk;

   always_comb begin
      col_v = 3'b111;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[r*3 + c] && kp.row_out[r] === 1'b0) col_v[c] = 1'b0;
   end
   assign kp.col_in = col_v;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [15:0] digit_t(input int d);
      return {10'd1 << d, 4'(d), 1'b1, 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic expect_at(input int due, input logic [15:0] t, input logic s, input logic st);
      exp_t e;
      e.due = due; e.tup = t; e.set_e = s; e.star_e = st;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Asserts rst mid-cycle, checks the asynchronous clear, releases on a negedge.
   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_row", 32'(kp.row_out), 32'h0000_000E);
      chk("rst_out", 32'({kp.num_out, kp.key_code, kp.key_valid, kp.multi_key}), 32'(NONE_T));
      chk("rst_pulse", 32'({kp.set_pulse, kp.star_pulse}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pulse_hold", 32'({kp.set_pulse, kp.star_pulse}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Output-change monitor: every change must match the next queued expectation.
   logic [15:0] last = NONE_T;
   always begin
      logic [15:0] cur;
      exp_t        e;
      @(posedge clk);
      #1;
      if (rst) begin
         last = NONE_T;
      end else if (mon_on) begin
         cur = {kp.num_out, kp.key_code, kp.key_valid, kp.multi_key};
         if (kp.set_pulse)  set_cnt++;
         if (kp.star_pulse) star_cnt++;
         if (cur !== last || kp.set_pulse !== 1'b0 || kp.star_pulse !== 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_change", 32'(cur), 32'(last));
               chk("unexpected_pulse", 32'({kp.set_pulse, kp.star_pulse}), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("evt_cycle", 32'(cyc), 32'(e.due));
               chk("evt_out", 32'(cur), 32'(e.tup));
               chk("evt_set", 32'(kp.set_pulse), 32'(e.set_e));
               chk("evt_star", 32'(kp.star_pulse), 32'(e.star_e));
            end
         end
         last = cur;
      end
   end

   initial begin
      #100000;
      $error("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset, then press/release '5'
      do_reset();
      mon_on = 1'b1;
      @(posedge clk);
      rst = 1'b1;
      pressed = 12'd1 << K5;
      expect_at(49, digit_t(5), 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(4);
      chk("row_step", 32'(kp.row_out), 32'h0000_000D);
      wait_cyc(48);
      chk("press5_before", 32'(kp.key_code), 32'd15);
      wait_cyc(49);
      chk("press5_num", 32'(kp.num_out), 32'b0000100000);
      wait_cyc(64);
      pressed = '0;
      expect_at(113, NONE_T, 1'b0, 1'b0);
      wait_cyc(120);
      chk("rel5_code", 32'(kp.key_code), 32'd15);

      // bounce on '7'
      do_reset();
      pressed = 12'd1 << K7;
      expect_at(113, digit_t(7), 1'b0, 1'b0);
      for (int t = 5; t < 60; t += 5) begin
         wait_cyc(t);
         pressed = pressed ^ (12'd1 << K7);
      end
      wait_cyc(60);
      pressed = 12'd1 << K7;
      wait_cyc(112);
      chk("bounce_hold", 32'(kp.num_out), 32'd0);
      wait_cyc(113);
      chk("bounce_num7", 32'(kp.num_out[7]), 32'd1);

      // hold '#' for 1000 cycles, release, press again
      do_reset();
      pressed = 12'd1 << KH;
      expect_at(49, HASH_T, 1'b1, 1'b0);
      wait_cyc(1000);
      chk("hash_pulses", 32'(set_cnt), 32'd1);
      chk("hash_valid", 32'({kp.key_code, kp.key_valid, kp.num_out}), 32'({4'd11, 1'b1, 10'd0}));
      pressed = '0;
      expect_at(1041, NONE_T, 1'b0, 1'b0);
      wait_cyc(1056);
      pressed = 12'd1 << KH;
      expect_at(1105, HASH_T, 1'b1, 1'b0);
      wait_cyc(1110);
      chk("hash_repress", 32'(set_cnt), 32'd2);

      // '2' and '8' together, then release '8'
      do_reset();
      pressed = (12'd1 << K2) | (12'd1 << K8);
      expect_at(49, MULTI_T, 1'b0, 1'b0);
      wait_cyc(64);
      chk("multi_flag", 32'({kp.multi_key, kp.key_valid}), 32'b10);
      pressed = 12'd1 << K2;
      expect_at(113, digit_t(2), 1'b0, 1'b0);
      wait_cyc(120);

      // direct change '1' -> '3', then reset while '3' is held
      do_reset();
      pressed = 12'd1 << K1;
      expect_at(49, digit_t(1), 1'b0, 1'b0);
      wait_cyc(64);
      pressed = 12'd1 << K3;
      expect_at(113, digit_t(3), 1'b0, 1'b0);
      wait_cyc(112);
      chk("direct_before", 32'(kp.num_out), 32'b0000000010);
      wait_cyc(113);
      chk("direct_after", 32'(kp.num_out), 32'b0000001000);
      wait_cyc(130);
      do_reset();
      expect_at(49, digit_t(3), 1'b0, 1'b0);
      wait_cyc(60);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("set_total", 32'(set_cnt), 32'd2);
      chk("star_total", 32'(star_cnt), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
